// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encodings, next-PC selects and reset/bubble constants.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2,
    S_HAVE = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2,
    PC_PEND   = 2'd3
  } pc_sel_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_pc_unit.sv
// Fetch PC register with its next-PC mux (hold / +4 / redirect / pending redirect).
import mips_pkg::*;

module if_pc_unit #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_e     pc_sel_i,
  input  logic [31:0] branch_addr_i,
  input  logic [31:0] pend_target_i,
  output logic [31:0] fetch_pc_o
);

  logic [31:0] fetch_pc_q;
  logic [31:0] fetch_pc_d;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    case (pc_sel_i)
      PC_HOLD:   fetch_pc_d = fetch_pc_q;
      PC_INC:    fetch_pc_d = fetch_pc_q + 32'd4;  // wraps modulo 2^32
      PC_BRANCH: fetch_pc_d = branch_addr_i;
      PC_PEND:   fetch_pc_d = pend_target_i;
      default:   fetch_pc_d = fetch_pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the Imem req/ack handshake and presents
// {PC+4, Instruction} to IF/ID, with a NOP bubble whenever no fetched word is held.
import mips_pkg::*;

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Freeze,
  input  logic         Branch_taken,
  input  logic [31:0]  Branch_Address,
  output logic         Imem_Req,
  output logic [31:0]  Imem_Addr,
  input  logic         Imem_Ack,
  input  logic [31:0]  Imem_Rdata,
  output logic [31:0]  PC,
  output logic [31:0]  Instruction,
  output logic         Valid,
  output logic         Fetch_Stall,
  output fetch_state_e Fsm_State
);

  // Handshake: Imem_Req stays high with Imem_Addr frozen until the cycle Imem_Ack is seen;
  // that cycle completes the transfer and Imem_Rdata is only meaningful alongside it.
  fetch_state_e state_q, state_d;
  logic [31:0]  inst_buf_q, inst_buf_d;
  logic [31:0]  pend_target_q, pend_target_d;
  pc_sel_e      pc_sel;
  logic [31:0]  fetch_pc;

  if_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk           (clk),
    .rst           (rst),
    .pc_sel_i      (pc_sel),
    .branch_addr_i (Branch_Address),
    .pend_target_i (pend_target_q),
    .fetch_pc_o    (fetch_pc)
  );

  always_comb begin
    state_d       = state_q;
    inst_buf_d    = inst_buf_q;
    pend_target_d = pend_target_q;
    pc_sel        = PC_HOLD;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (Branch_taken) begin
          if (Imem_Ack) begin
            pc_sel = PC_BRANCH;
          end else begin
            pend_target_d = Branch_Address;
            state_d       = S_KILL;
          end
        end else if (Imem_Ack) begin
          inst_buf_d = Imem_Rdata;
          state_d    = S_HAVE;
        end
      end
      S_KILL: begin
        // The stale request must finish before the redirected one can be issued.
        if (Branch_taken) pend_target_d = Branch_Address;
        if (Imem_Ack) begin
          pc_sel  = Branch_taken ? PC_BRANCH : PC_PEND;
          state_d = S_REQ;
        end
      end
      S_HAVE: begin
        if (Branch_taken) begin
          pc_sel  = PC_BRANCH;
          state_d = S_REQ;
        end else if (!Freeze) begin
          pc_sel  = PC_INC;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      inst_buf_q    <= 32'h0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      inst_buf_q    <= inst_buf_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign Imem_Req    = (state_q == S_REQ) || (state_q == S_KILL);
  assign Imem_Addr   = fetch_pc;
  assign Valid       = (state_q == S_HAVE);
  assign Fetch_Stall = ~Valid;
  assign Instruction = Valid ? inst_buf_q : NOP_INST;
  assign PC          = fetch_pc + 32'd4;
  assign Fsm_State   = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Cycle-by-cycle vector table for the fetch stage, with a queue of accepted words
// checked when each word is presented to IF/ID.
import mips_pkg::*;

module tb_if_fetch_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         Freeze;
  logic         Branch_taken;
  logic [31:0]  Branch_Address;
  logic         Imem_Req;
  logic [31:0]  Imem_Addr;
  logic         Imem_Ack;
  logic [31:0]  Imem_Rdata;
  logic [31:0]  PC;
  logic [31:0]  Instruction;
  logic         Valid;
  logic         Fetch_Stall;
  fetch_state_e Fsm_State;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .Freeze         (Freeze),
    .Branch_taken   (Branch_taken),
    .Branch_Address (Branch_Address),
    .Imem_Req       (Imem_Req),
    .Imem_Addr      (Imem_Addr),
    .Imem_Ack       (Imem_Ack),
    .Imem_Rdata     (Imem_Rdata),
    .PC             (PC),
    .Instruction    (Instruction),
    .Valid          (Valid),
    .Fetch_Stall    (Fetch_Stall),
    .Fsm_State      (Fsm_State)
  );

  // Expected outputs describe the cycle as seen before the edge; inputs act at the edge.
  typedef struct {
    logic         rst, frz, bt;
    logic [31:0]  ba;
    logic         ack;
    logic [31:0]  rd;
    logic         keep;
    fetch_state_e st;
    logic         req;
    logic [31:0]  addr;
    logic         vld;
    logic [31:0]  pc;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] cur_word;
  logic        prev_vld;

  function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] ba,
                              input logic a, input logic [31:0] rd, input logic keep,
                              input fetch_state_e st, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.frz = f; v.bt = b; v.ba = ba; v.ack = a; v.rd = rd; v.keep = keep;
    v.st = st; v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    logic [63:0] w;
    //            rst f  bt ba            ack rd         keep st      req addr          vld pc
    // 0-wait fetches 0,4,8
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_IDLE, 0, 32'h0,        0, 32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 1, S_REQ,  1, 32'h0,        0, 32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'h0,        1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 1, S_REQ,  1, 32'h4,        0, 32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'h4,        1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 1, S_REQ,  1, 32'h8,        0, 32'hC));
    // Freeze held for 4 cycles in S_HAVE; stray Ack ignored there
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'h8,        1, 32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, $urandom(), 0, S_HAVE, 0, 32'h8,        1, 32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'h8,        1, 32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'h8,        1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'h8,        1, 32'hC));
    // Ack delayed by 3 cycles
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_REQ,  1, 32'hC,        0, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_REQ,  1, 32'hC,        0, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_REQ,  1, 32'hC,        0, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 1, S_REQ,  1, 32'hC,        0, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'hC,        1, 32'h10));
    // Redirect to 0x40 before Ack, returned word dropped
    tbl.push_back(mk(0, 0, 1, 32'h40,       0, $urandom(), 0, S_REQ,  1, 32'h10,       0, 32'h14));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 0, S_KILL, 1, 32'h10,       0, 32'h14));
    // Redirect to 0x60 then 0x80 while killing: newest wins
    tbl.push_back(mk(0, 0, 1, 32'h60,       0, $urandom(), 0, S_REQ,  1, 32'h40,       0, 32'h44));
    tbl.push_back(mk(0, 0, 1, 32'h80,       0, $urandom(), 0, S_KILL, 1, 32'h40,       0, 32'h44));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 0, S_KILL, 1, 32'h40,       0, 32'h44));
    // Redirect coinciding with Ack in S_REQ
    tbl.push_back(mk(0, 0, 1, 32'hC0,       1, $urandom(), 0, S_REQ,  1, 32'h80,       0, 32'h84));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 1, S_REQ,  1, 32'hC0,       0, 32'hC4));
    // Branch beats Freeze in S_HAVE
    tbl.push_back(mk(0, 1, 1, 32'h100,      0, $urandom(), 0, S_HAVE, 0, 32'hC0,       1, 32'hC4));
    // Reset while S_KILL waits; stray Ack in S_IDLE ignored
    tbl.push_back(mk(0, 0, 1, 32'h200,      0, $urandom(), 0, S_REQ,  1, 32'h100,      0, 32'h104));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, $urandom(), 0, S_KILL, 1, 32'h100,      0, 32'h104));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 0, S_IDLE, 0, 32'h0,        0, 32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 1, S_REQ,  1, 32'h0,        0, 32'h4));
    // PC+4 wraps at the top of the address space
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, $urandom(), 0, S_HAVE, 0, 32'h0,       1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, $urandom(), 1, S_REQ,  1, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_HAVE, 0, 32'hFFFF_FFFC, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, $urandom(), 0, S_REQ,  1, 32'h0,        0, 32'h4));

    rst = 1'b1; Freeze = 1'b0; Branch_taken = 1'b0; Branch_Address = 32'h0;
    Imem_Ack = 1'b0; Imem_Rdata = 32'h0;
    cur_word = 32'h0;
    prev_vld = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk("state", i, 32'(Fsm_State), 32'(tbl[i].st));
      chk("imem_req", i, 32'(Imem_Req), 32'(tbl[i].req));
      if (tbl[i].req) chk("imem_addr", i, Imem_Addr, tbl[i].addr);
      chk("valid", i, 32'(Valid), 32'(tbl[i].vld));
      chk("fetch_stall", i, 32'(Fetch_Stall), 32'(!tbl[i].vld));
      if (tbl[i].vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL word_queue cycle %0d: word presented with nothing expected", i);
        end else begin
          w = exp_q.pop_front();
          cur_word = w[31:0];
          chk("word_pc", i, PC, w[63:32]);
        end
      end
      chk("pc", i, PC, tbl[i].pc);
      chk("instruction", i, Instruction, tbl[i].vld ? cur_word : 32'h0);
      prev_vld = tbl[i].vld;

      rst            = tbl[i].rst;
      Freeze         = tbl[i].frz;
      Branch_taken   = tbl[i].bt;
      Branch_Address = tbl[i].ba;
      Imem_Ack       = tbl[i].ack;
      Imem_Rdata     = tbl[i].rd;
      if (tbl[i].keep) exp_q.push_back({tbl[i].addr + 32'd4, tbl[i].rd});
    end

    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL word_queue end: got %0d words left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
